// File: rtl/resp_packer_pkg.sv
// Shared definitions for the response packer: FSM state encoding,
// default byte/ALU widths and the byte-count type.
package resp_packer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ALU_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_CSUM  = 2'd3
  } state_t;

  // Number of data bytes in the captured response (1 = read data, 2 = ALU)
  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_ONE = 2'd1;
  localparam cnt_t CNT_TWO = 2'd2;

endpackage

// File: rtl/resp_packer.sv
// Response packer: captures an ALU result or register read and serialises it
// LSB-first into an async FIFO write port, stalling on FIFO_FULL.
// Optional trailing XOR checksum byte when RESP_PACKER_CHECKSUM_EN is defined.
module resp_packer
  import resp_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ALU_WIDTH  = ALU_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_Valid,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  Busy,
  output logic                  Drop
);

  state_t               state;
  state_t               state_nxt;
  state_t               after_data;
  logic [ALU_WIDTH-1:0] cap;
  cnt_t                 cnt;
  logic                 wr;
  logic [DATA_WIDTH-1:0] byte_lo;
  logic [DATA_WIDTH-1:0] byte_hi;

  assign byte_lo = cap[DATA_WIDTH-1:0];
  assign byte_hi = cap[2*DATA_WIDTH-1:DATA_WIDTH];

  // A byte leaves whenever a response is pending and the FIFO has room
  assign wr = (state != ST_IDLE) && !FIFO_FULL;

`ifdef RESP_PACKER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  // XOR of the data bytes actually carried by this response
  assign csum       = byte_lo ^ ((cnt == CNT_TWO) ? byte_hi : '0);
  assign after_data = ST_CSUM;
`else
  assign after_data = ST_IDLE;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave IDLE on any strobe, otherwise advance only on a write
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (OUT_Valid || RdData_Valid) begin
          state_nxt = ST_BYTE0;
        end
      end
      ST_BYTE0: begin
        if (wr) begin
          state_nxt = (cnt == CNT_ONE) ? after_data : ST_BYTE1;
        end
      end
      ST_BYTE1: begin
        if (wr) begin
          state_nxt = after_data;
        end
      end
      ST_CSUM: begin
`ifdef RESP_PACKER_CHECKSUM_EN
        if (wr) begin
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture register and byte count, loaded only from IDLE (ALU has priority)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap <= '0;
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (OUT_Valid) begin
        cap <= ALU_OUT;
        cnt <= CNT_TWO;
      end else if (RdData_Valid) begin
        cap <= ALU_WIDTH'(RdData);
        cnt <= CNT_ONE;
      end
    end
  end

  // Outputs: byte mux, write strobe, busy and discarded-strobe pulse
  always_comb begin
    TX_P_Data = '0;
    TX_D_VLD  = wr;
    Busy      = (state != ST_IDLE);
    Drop      = 1'b0;
    case (state)
      ST_BYTE0: TX_P_Data = byte_lo;
      ST_BYTE1: TX_P_Data = byte_hi;
`ifdef RESP_PACKER_CHECKSUM_EN
      ST_CSUM:  TX_P_Data = csum;
`endif
      default:  TX_P_Data = '0;
    endcase
    if (!RST) begin
      if (state == ST_IDLE) begin
        Drop = OUT_Valid && RdData_Valid;
      end else begin
        Drop = OUT_Valid || RdData_Valid;
      end
    end
  end

endmodule

// File: tb/tb_resp_packer.sv
// Scoreboard bench for resp_packer: expected FIFO bytes are queued when a
// strobe is driven and popped as the DUT writes. Honours RESP_PACKER_CHECKSUM_EN.
module tb_resp_packer;

`ifdef RESP_PACKER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_Valid;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        FIFO_FULL;
  logic [7:0]  TX_P_Data;
  logic        TX_D_VLD;
  logic        Busy;
  logic        Drop;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb[$];

  resp_packer #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ALU_OUT      (ALU_OUT),
    .OUT_Valid    (OUT_Valid),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .FIFO_FULL    (FIFO_FULL),
    .TX_P_Data    (TX_P_Data),
    .TX_D_VLD     (TX_D_VLD),
    .Busy         (Busy),
    .Drop         (Drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every FIFO write must match the oldest expected byte
  always @(negedge CLK) begin
    if (!RST && TX_D_VLD) begin
      check("vld_while_full", 32'(FIFO_FULL), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_wr", 32'(TX_D_VLD), 32'd0);
      end else begin
        check("wr_data", 32'(TX_P_Data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic push_resp(input bit is_alu, input logic [15:0] a, input logic [7:0] d);
    if (is_alu) begin
      sb.push_back(a[7:0]);
      sb.push_back(a[15:8]);
      if (CSUM_EN) sb.push_back(a[7:0] ^ a[15:8]);
    end else begin
      sb.push_back(d);
      if (CSUM_EN) sb.push_back(d);
    end
  endtask

  // Drive strobes for one cycle, check Drop mid-cycle, end at next posedge+1
  task automatic send(input bit alu, input bit rd, input logic [15:0] a,
                      input logic [7:0] d, input bit exp_drop, input string tag);
    OUT_Valid    = alu;
    RdData_Valid = rd;
    ALU_OUT      = a;
    RdData       = d;
    @(negedge CLK);
    check(tag, 32'(Drop), 32'(exp_drop));
    @(posedge CLK); #1;
    OUT_Valid    = 1'b0;
    RdData_Valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_full);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!Busy) begin
        done = 1'b1;
        break;
      end
      FIFO_FULL = rnd_full ? ($urandom_range(0, 9) < 3) : 1'b0;
      @(posedge CLK); #1;
    end
    FIFO_FULL = 1'b0;
    if (!done) check("idle_timeout", 32'(Busy), 32'd0);
  endtask

  initial begin
    int lat;
    bit is_alu;
    logic [15:0] ra;
    logic [7:0]  rd;

    RST = 1'b1; FIFO_FULL = 1'b0;
    OUT_Valid = 1'b1; RdData_Valid = 1'b1; ALU_OUT = 16'hFFFF; RdData = 8'hFF;
    #3;
    check("rst_data", 32'(TX_P_Data), 32'd0);
    check("rst_vld",  32'(TX_D_VLD),  32'd0);
    check("rst_busy", 32'(Busy),      32'd0);
    check("rst_drop", 32'(Drop),      32'd0);
    repeat (3) @(posedge CLK);
    #1;
    OUT_Valid = 1'b0; RdData_Valid = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;

    // ALU A55A: latency and LSB-first ordering
    push_resp(1'b1, 16'hA55A, 8'h00);
    send(1'b1, 1'b0, 16'hA55A, 8'h00, 1'b0, "drop_a55a");
    @(negedge CLK);
    check("lat_first_vld", 32'(TX_D_VLD), 32'd1);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (!Busy) break;
    end
    check("lat_idle", 32'(lat), CSUM_EN ? 32'd4 : 32'd3);

    // Read data 3C stalled by FIFO_FULL for four cycles
    push_resp(1'b0, 16'h0000, 8'h3C);
    FIFO_FULL = 1'b1;
    send(1'b0, 1'b1, 16'h0000, 8'h3C, 1'b0, "drop_3c");
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      check("stall_vld",  32'(TX_D_VLD),  32'd0);
      check("stall_data", 32'(TX_P_Data), 32'h3C);
      @(posedge CLK); #1;
      if (i == 4) FIFO_FULL = 1'b0;
    end
    @(negedge CLK);
    check("stall_release_vld", 32'(TX_D_VLD), 32'd1);
    @(posedge CLK); #1;
    wait_idle(1'b0);

    // Both strobes together: ALU wins, read data dropped
    push_resp(1'b1, 16'h0102, 8'h00);
    send(1'b1, 1'b1, 16'h0102, 8'hFF, 1'b1, "drop_both");
    wait_idle(1'b0);

    // Strobe during BYTE1 is discarded without disturbing the response
    push_resp(1'b1, 16'h1234, 8'h00);
    send(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, "drop_1234");
    @(posedge CLK); #1;
    send(1'b0, 1'b1, 16'h0000, 8'h77, 1'b1, "drop_byte1");
    wait_idle(1'b0);

    // Strobe while the final byte is written is dropped; next one accepted
    push_resp(1'b0, 16'h0000, 8'hC3);
    send(1'b0, 1'b1, 16'h0000, 8'hC3, 1'b0, "drop_c3");
    send(1'b1, 1'b0, 16'hBEEF, 8'h00, 1'b1, "drop_b2b");
    wait_idle(1'b0);
    push_resp(1'b1, 16'hBEEF, 8'h00);
    send(1'b1, 1'b0, 16'hBEEF, 8'h00, 1'b0, "drop_after_idle");
    wait_idle(1'b0);

    // Reset in BYTE1 with FIFO full abandons the rest of the response
    sb.push_back(8'h5A);
    send(1'b1, 1'b0, 16'hA55A, 8'h00, 1'b0, "drop_pre_rst");
    @(posedge CLK); #1;
    FIFO_FULL = 1'b1;
    @(negedge CLK);
    check("pre_rst_busy", 32'(Busy), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_vld",  32'(TX_D_VLD),  32'd0);
    check("mid_rst_data", 32'(TX_P_Data), 32'd0);
    check("mid_rst_busy", 32'(Busy),      32'd0);
    check("mid_rst_drop", 32'(Drop),      32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("post_rst_vld", 32'(TX_D_VLD), 32'd0);
    end
    @(posedge CLK); #1;

    // Random responses with random back-pressure
    for (int n = 0; n < 24; n++) begin
      is_alu = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rd = 8'($urandom);
      FIFO_FULL = ($urandom_range(0, 9) < 3);
      push_resp(is_alu, ra, rd);
      send(is_alu, !is_alu, ra, rd, 1'b0, "drop_rand");
      wait_idle(1'b1);
    end

    repeat (3) @(posedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
